// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes, vectors, fetch FSM states.
// Used by the fetch stage and the control unit.
package cpu_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;
  localparam logic [2:0] PCSRC_IRQ = 3'd4;
  localparam logic [2:0] PCSRC_EXC = 3'd5;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

  typedef enum logic {
    S_FETCH,
    S_EXEC
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory req/ack fetch channel.
// master = fetch stage, slave = instruction memory.
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC target mux.
// All adds wrap modulo 2^32.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [2:0]  pc_src,
  input  logic        br_cond,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;

  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PCSRC_BR: begin
        if (br_cond)
          next_pc = pc_plus4 + br_off;
      end
      PCSRC_J:
        next_pc = {pc[31], pc_plus4[30:28],
                   instr[25:0], 2'b00};
      // a jr can never set the supervisor bit
      PCSRC_JR:
        next_pc = {pc[31] & rs_data[31],
                   rs_data[30:0]};
      PCSRC_IRQ: next_pc = IRQ_VEC;
      PCSRC_EXC: next_pc = EXC_VEC;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register, fetch FSM and interrupt latch.
// Holds one instruction for control until it commits.
module pc_fetch
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  pc_fetch_if.master  imem,
  output logic [31:0] Instruct,
  output logic        InstValid,
  output logic [31:0] PC,
  output logic        PC31,
  output logic [31:0] PCPlus4,
  input  logic        IRQ,
  output logic        IrqPend,
  input  logic [2:0]  PCSrc,
  input  logic        BrCond,
  input  logic [31:0] RsData,
  input  logic        Stall
);

  fetch_state_t state, state_n;
  logic         in_fetch;
  logic         in_exec;
  logic         commit;
  logic         irq_clr;
  logic [31:0]  next_pc;

  assign in_fetch = (state == S_FETCH);
  assign in_exec  = (state == S_EXEC);
  assign commit   = in_exec & ~Stall;
  assign irq_clr  = commit & (PCSrc == PCSRC_IRQ);

  assign imem.req  = in_fetch;
  assign imem.addr = PC;
  assign InstValid = in_exec;
  assign PC31      = PC[31];
  assign PCPlus4   = PC + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_FETCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      in_fetch: if (imem.ack) state_n = S_EXEC;
      in_exec:  if (!Stall)   state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
  end

  // a new IRQ in the clearing cycle keeps the latch set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC       <= RESET_PC;
      Instruct <= 32'h0;
      IrqPend  <= 1'b0;
    end else begin
      if (in_fetch && imem.ack)
        Instruct <= imem.rdata;
      if (commit)
        PC <= next_pc;
      IrqPend <= IRQ | (IrqPend & ~irq_clr);
    end
  end

  next_pc_logic u_next_pc (
    .pc       (PC),
    .pc_plus4 (PCPlus4),
    .instr    (Instruct),
    .pc_src   (PCSrc),
    .br_cond  (BrCond),
    .rs_data  (RsData),
    .next_pc  (next_pc)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a per-cycle reference model.
// Literal checks pin the model on the interesting PC transitions.
module tb_pc_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instruct;
  logic        InstValid;
  logic [31:0] PC;
  logic        PC31;
  logic [31:0] PCPlus4;
  logic        IRQ = 1'b0;
  logic        IrqPend;
  logic [2:0]  PCSrc = 3'd0;
  logic        BrCond = 1'b0;
  logic [31:0] RsData = 32'h0;
  logic        Stall = 1'b0;
  logic        run = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  pc_fetch_if imem ();

  pc_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (imem.master),
    .Instruct  (Instruct),
    .InstValid (InstValid),
    .PC        (PC),
    .PC31      (PC31),
    .PCPlus4   (PCPlus4),
    .IRQ       (IRQ),
    .IrqPend   (IrqPend),
    .PCSrc     (PCSrc),
    .BrCond    (BrCond),
    .RsData    (RsData),
    .Stall     (Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_next(
    input logic [31:0] pc,
    input logic [31:0] ins,
    input logic [2:0]  src,
    input logic        br,
    input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    case (src)
      3'd1: return br ? seq + 32'(off * 4) : seq;
      3'd2: return (pc & 32'h8000_0000)
                 | (seq & 32'h7000_0000)
                 | {4'b0, ins[25:0], 2'b00};
      3'd3: return pc[31] ? rs : (rs & 32'h7FFF_FFFF);
      3'd4: return 32'h8000_0004;
      3'd5: return 32'h8000_0008;
      default: return seq;
    endcase
  endfunction

  // reference: one instruction = wait for ack, then wait for no stall
  logic [31:0] m_pc, m_ins;
  logic        m_exec, m_irq;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc   = 32'h8000_0000;
      m_ins  = 32'h0;
      m_exec = 1'b0;
      m_irq  = 1'b0;
    end else begin
      logic done;
      done = m_exec && !Stall;
      if (IRQ)
        m_irq = 1'b1;
      else if (done && PCSrc == 3'd4)
        m_irq = 1'b0;
      if (!m_exec) begin
        if (imem.ack) begin
          m_ins  = imem.rdata;
          m_exec = 1'b1;
        end
      end else if (done) begin
        m_pc   = ref_next(m_pc, m_ins, PCSrc, BrCond, RsData);
        m_exec = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("req", {31'b0, imem.req}, {31'b0, !m_exec});
      if (!m_exec)
        chk("addr", imem.addr, m_pc);
      chk("valid", {31'b0, InstValid}, {31'b0, m_exec});
      chk("instr", Instruct, m_ins);
      chk("pc", PC, m_pc);
      chk("pc31", {31'b0, PC31}, {31'b0, m_pc[31]});
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
      chk("irqpend", {31'b0, IrqPend}, {31'b0, m_irq});
    end
  end

  // called at a negedge with the DUT in fetch; returns at the
  // negedge after the commit cycle
  task automatic instr(input logic [31:0] w,
                       input int dly, input int stl,
                       input logic [2:0] src, input logic br,
                       input logic [31:0] rs);
    chk("in_fetch", {31'b0, imem.req}, 32'd1);
    Stall = (stl > 0);
    for (int i = 0; i < dly; i++) begin
      imem.ack = 1'b0;
      imem.rdata = $urandom;
      @(negedge clk);
    end
    imem.ack = 1'b1;
    imem.rdata = w;
    @(negedge clk);
    imem.ack = 1'b0;
    imem.rdata = $urandom;
    for (int i = 0; i < stl; i++) begin
      Stall = 1'b1;
      PCSrc = 3'd3;
      BrCond = 1'b1;
      RsData = $urandom;
      @(negedge clk);
    end
    Stall = 1'b0;
    PCSrc = src;
    BrCond = br;
    RsData = rs;
    @(negedge clk);
    PCSrc = 3'd0;
    BrCond = 1'b0;
    RsData = 32'h0;
  endtask

  initial begin
    imem.ack = 1'b0;
    imem.rdata = 32'h0;
    run = 1'b1;
    #12;
    chk("rst_pc", PC, 32'h8000_0000);
    chk("rst_ins", Instruct, 32'h0);
    chk("rst_valid", {31'b0, InstValid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("first_addr", imem.addr, 32'h8000_0000);
    instr(32'h2008_0005, 0, 0, 3'd0, 1'b0, 32'h0);
    chk("second_addr", imem.addr, 32'h8000_0004);
    instr(32'h2008_0005, 0, 0, 3'd0, 1'b0, 32'h0);
    chk("third_addr", imem.addr, 32'h8000_0008);

    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'h8000_0010);
    chk("jr_kernel_a", PC, 32'h8000_0010);
    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'h8000_0200);
    chk("jr_kernel_b", PC, 32'h8000_0200);
    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'h0000_0010);
    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'h8000_0200);
    chk("jr_no_escalate", PC, 32'h0000_0200);
    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'h0000_0100);

    instr(32'h1000_FFFF, 5, 4, 3'd1, 1'b1, 32'h0);
    chk("br_taken", PC, 32'h0000_0100);
    instr(32'h1000_FFFF, 0, 0, 3'd1, 1'b0, 32'h0);
    chk("br_not_taken", PC, 32'h0000_0104);
    instr(32'h0800_0040, 0, 2, 3'd2, 1'b0, 32'h0);
    chk("jump", PC, 32'h0000_0100);

    imem.ack = 1'b1;
    imem.rdata = 32'h0;
    @(negedge clk);
    imem.ack = 1'b0;
    Stall = 1'b1;
    IRQ = 1'b1;
    @(negedge clk);
    IRQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("irq_held", {31'b0, IrqPend}, 32'd1);
    Stall = 1'b0;
    PCSrc = 3'd4;
    IRQ = 1'b1;
    @(negedge clk);
    IRQ = 1'b0;
    PCSrc = 3'd0;
    chk("irq_vec", PC, 32'h8000_0004);
    chk("irq_set_wins", {31'b0, IrqPend}, 32'd1);
    instr(32'h0, 0, 0, 3'd4, 1'b0, 32'h0);
    chk("irq_cleared", {31'b0, IrqPend}, 32'd0);

    instr(32'h0, 0, 0, 3'd5, 1'b0, 32'h0);
    chk("exc_vec", PC, 32'h8000_0008);
    instr(32'h0, 0, 0, 3'd3, 1'b0, 32'hFFFF_FFFC);
    chk("jr_top", PC, 32'hFFFF_FFFC);
    instr(32'h0, 0, 0, 3'd0, 1'b0, 32'h0);
    chk("wrap", PC, 32'h0000_0000);
    instr(32'hDEAD_BEEF, 0, 0, 3'd0, 1'b0, 32'h0);

    IRQ = 1'b1;
    @(negedge clk);
    IRQ = 1'b0;
    chk("pre_rst_irq", {31'b0, IrqPend}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", PC, 32'h8000_0000);
    chk("arst_ins", Instruct, 32'h0);
    chk("arst_irq", {31'b0, IrqPend}, 32'd0);
    chk("arst_valid", {31'b0, InstValid}, 32'd0);
    chk("arst_req", {31'b0, imem.req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    chk("restart_addr", imem.addr, 32'h8000_0000);
    instr(32'h2008_0005, 1, 0, 3'd0, 1'b0, 32'h0);
    chk("restart_next", PC, 32'h8000_0004);

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
